// File: rtl/baccarat_hand_sequencer_if.sv
// rtl/baccarat_hand_sequencer_if.sv - card/score datapath handshake bundle for the hand sequencer
interface baccarat_hand_sequencer_if;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;

    // master: the sequencer; slave: the card/score datapath
    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light
    );
endinterface

// File: rtl/baccarat_hand_sequencer.sv
// rtl/baccarat_hand_sequencer.sv - baccarat deal/draw controller; HAND_COUNT_EN adds hand_count
module baccarat_hand_sequencer (
    input  logic                        slow_clock,
    input  logic                        resetb,
`ifdef HAND_COUNT_EN
    output logic [7:0]                  hand_count,
`endif
    baccarat_hand_sequencer_if.master   bus
);

    typedef enum logic [3:0] {
        S_RST,
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_EV1,
        S_P3,
        S_EV2,
        S_D3,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       done_q;
    logic [3:0] p3_value;
    logic       dealer_hit;

    // Face and ten cards count as zero; out-of-range codes fold to zero too.
    always_comb begin
        p3_value = 4'd0;
        if (bus.pcard3 >= 4'd1 && bus.pcard3 <= 4'd9)
            p3_value = bus.pcard3;
    end

    always_comb begin
        dealer_hit = 1'b0;
        case (bus.dscore)
            4'd0, 4'd1, 4'd2: dealer_hit = 1'b1;
            4'd3:             dealer_hit = (p3_value != 4'd8);
            4'd4:             dealer_hit = (p3_value >= 4'd2) && (p3_value <= 4'd7);
            4'd5:             dealer_hit = (p3_value >= 4'd4) && (p3_value <= 4'd7);
            4'd6:             dealer_hit = (p3_value >= 4'd6) && (p3_value <= 4'd7);
            default:          dealer_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RST:  state_nx = S_P1;
            S_P1:   state_nx = S_D1;
            S_D1:   state_nx = S_P2;
            S_P2:   state_nx = S_D2;
            S_D2:   state_nx = S_EV1;
            S_EV1: begin
                // Scores of 8 and above (including illegal 10-15) end the hand as naturals.
                if (bus.pscore >= 4'd8 || bus.dscore >= 4'd8)
                    state_nx = S_DONE;
                else if (bus.pscore <= 4'd5)
                    state_nx = S_P3;
                else if (bus.dscore <= 4'd5)
                    state_nx = S_D3;
                else
                    state_nx = S_DONE;
            end
            S_P3:   state_nx = S_EV2;
            S_EV2:  state_nx = dealer_hit ? S_D3 : S_DONE;
            S_D3:   state_nx = S_DONE;
            S_DONE: state_nx = S_DONE;
            default: state_nx = S_RST;
        endcase
    end

    // Strobes are registered decodes of the next state, so they track the current state exactly.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state           <= S_RST;
            bus.load_pcard1 <= 1'b0;
            bus.load_dcard1 <= 1'b0;
            bus.load_pcard2 <= 1'b0;
            bus.load_dcard2 <= 1'b0;
            bus.load_pcard3 <= 1'b0;
            bus.load_dcard3 <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state           <= state_nx;
            bus.load_pcard1 <= (state_nx == S_P1);
            bus.load_dcard1 <= (state_nx == S_D1);
            bus.load_pcard2 <= (state_nx == S_P2);
            bus.load_dcard2 <= (state_nx == S_D2);
            bus.load_pcard3 <= (state_nx == S_P3);
            bus.load_dcard3 <= (state_nx == S_D3);
            done_q          <= (state_nx == S_DONE);
        end
    end

`ifdef HAND_COUNT_EN
    always_ff @(posedge slow_clock) begin
        if (!resetb)
            hand_count <= 8'd0;
        else if (state != S_DONE && state_nx == S_DONE && hand_count != 8'hFF)
            hand_count <= hand_count + 8'd1;
    end
`endif

    // Ties light both lamps.
    assign bus.player_win_light = done_q && (bus.pscore >= bus.dscore);
    assign bus.dealer_win_light = done_q && (bus.dscore >= bus.pscore);

endmodule
